mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 122 ++++++++++++
 tb/tb_mdu.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency mult/div with HI/LO result registers.
// Results are computed at the start edge, then held until the busy countdown expires.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [1:0]  state;
    logic [3:0]  count;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;

    // Returns the full 64-bit product; sign-extending both operands makes the low 64 bits exact.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] prod;
        sa   = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        sb   = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        prod = sa * sb;
        return prod;
    endfunction

    // Returns {remainder, quotient}. Works on magnitudes so 0x80000000 / -1 wraps cleanly.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        ma    = neg_a ? (~a + 32'd1) : a;
        mb    = neg_b ? (~b + 32'd1) : b;
        q     = (mb != 32'd0) ? (ma / mb) : 32'd0;
        r     = (mb != 32'd0) ? (ma % mb) : 32'd0;
        if (neg_a ^ neg_b) q = ~q + 32'd1;
        if (neg_a)         r = ~r + 32'd1;
        return {r, q};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            busy     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            res_hi   <= 32'd0;
            res_lo   <= 32'd0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                {res_hi, res_lo} <= mul64(rs, rt, md_op == OP_MULT);
                                div_zero         <= 1'b0;
                                count            <= MULT_LOAD;
                                busy             <= 1'b1;
                                state            <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                {res_hi, res_lo} <= div64(rs, rt, md_op == OP_DIV);
                                div_zero         <= (rt == 32'd0);
                                count            <= DIV_LOAD;
                                busy             <= 1'b1;
                                state            <= DIV;
                            end
                            OP_MTHI: hi <= rs;
                            OP_MTLO: lo <= rs;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    // start is deliberately ignored here; only the countdown advances
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        if (!div_zero) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed and randomized operations against a plain-arithmetic HI/LO model.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs = 32'd0;
    logic [31:0] rt = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total = 0;
    int          passed = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always #5 clk = ~clk;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Architectural effect of one accepted operation; returns how long busy should stay high.
    function automatic int model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint          q;
        longint          r;
        longint unsigned up;
        int              cyc;
        cyc = 0;
        case (op)
            3'd1: begin
                sp = longint'(signed'(a)) * longint'(signed'(b));
                exp_hi = sp[63:32];
                exp_lo = sp[31:0];
                cyc = MC;
            end
            3'd2: begin
                up = {32'd0, a} * {32'd0, b};
                exp_hi = up[63:32];
                exp_lo = up[31:0];
                cyc = MC;
            end
            3'd3: begin
                if (b != 32'd0) begin
                    q = longint'(signed'(a)) / longint'(signed'(b));
                    r = longint'(signed'(a)) % longint'(signed'(b));
                    exp_lo = q[31:0];
                    exp_hi = r[31:0];
                end
                cyc = DC;
            end
            3'd4: begin
                if (b != 32'd0) begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
                cyc = DC;
            end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
        return cyc;
    endfunction

    // Drives start for exactly one rising edge, then scrambles operands to prove they were latched.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        rs    = a;
        rt    = b;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'($urandom);
        rs    = $urandom;
        rt    = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int cyc;
        int n;
        cyc = model(op, a, b);
        issue(op, a, b);
        wait_done(n);
        check({tag, "_cycles"}, 32'(n), 32'(cyc));
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int          n;
        int          cyc;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        // Reset is asynchronous: outputs must be clear before any clock edge
        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        // First start honoured on the very first rising edge after release
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        md_op = 3'd6;
        rs    = 32'hCAFE_0001;
        @(negedge clk);
        start = 1'b0;
        exp_lo = 32'hCAFE_0001;
        check("first_start_lo", lo, exp_lo);
        check("first_start_busy", 32'(busy), 32'd0);

        run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_lo_const", lo, 32'hFFFF_FFFE);

        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        check("multu_hi_const", hi, 32'h0000_0001);
        check("multu_lo_const", lo, 32'hFFFF_FFFE);

        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        check("div_hi_const", hi, 32'hFFFF_FFFF);

        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_const", lo, 32'h8000_0000);
        check("div_ovf_hi_const", hi, 32'h0000_0000);

        run_op("mtlo_zero", 3'd6, 32'h0000_0000, 32'h0);
        run_op("mthi", 3'd5, 32'h1234_5678, 32'h0);
        run_op("divu_zero", 3'd4, 32'h0000_0007, 32'h0000_0000);
        check("divu_zero_hi_const", hi, 32'h1234_5678);
        check("divu_zero_lo_const", lo, 32'h0000_0000);

        run_op("nop0", 3'd0, 32'h5555_5555, 32'h1);
        run_op("nop7", 3'd7, 32'hAAAA_AAAA, 32'h1);

        // mtlo arriving in the second busy cycle of a mult must be dropped
        cyc = model(3'd1, 32'h0001_0003, 32'h0002_0005);
        issue(3'd1, 32'h0001_0003, 32'h0002_0005);
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd6;
        rs    = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("busy_ignore_cycles", 32'(n), 32'(cyc - 2));
        check("busy_ignore_hi", hi, exp_hi);
        check("busy_ignore_lo", lo, exp_lo);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b);
        end

        // Abort a divide with an asynchronous reset in its fourth busy cycle
        run_op("pre_abort_mthi", 3'd5, 32'h0BAD_F00D, 32'h0);
        issue(3'd3, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check("abort_busy_now", 32'(busy), 32'd0);
        check("abort_hi_now", hi, exp_hi);
        check("abort_lo_now", lo, exp_lo);
        #1 reset = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_busy_later", 32'(busy), 32'd0);
        check("abort_hi_later", hi, exp_hi);
        check("abort_lo_later", lo, exp_lo);

        run_op("post_abort_div", 3'd3, 32'd100, 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
